// File: rtl/sar_search.sv
// sar_search: SAR-style binary-search initiator driving a magnitude comparator's b operand.
// Optional probe counter output enabled by defining SAR_PROBE_CNT_EN.
module sar_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  input  logic             gr,
  input  logic             ls,
  input  logic             eq,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result
`ifdef SAR_PROBE_CNT_EN
  ,output logic [$clog2(WIDTH+2)-1:0] probes
`endif
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PROBE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, result_q, result_d, mid;
  logic             found_q, found_d, err_q, err_d;
  logic [WIDTH:0]   sum;
  // midpoint at WIDTH+1 bits so lo+hi never wraps
  assign sum    = {1'b0, lo_q} + {1'b0, hi_q};
  assign mid    = WIDTH'(sum >> 1);
  assign busy   = state_q == PROBE;
  assign done   = state_q == DONE;
  assign guess  = busy ? mid : '0;
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    found_d  = found_q;
    err_d    = err_q;
    result_d = result_q;
    if (state_q == IDLE && start) begin
      state_d  = PROBE;
      lo_d     = '0;
      hi_d     = '1;
      found_d  = 1'b0;
      err_d    = 1'b0;
      result_d = '0;
    end else if (state_q == PROBE) begin
      if (!$onehot({gr, ls, eq}) || (gr && mid == hi_q) || (ls && mid == lo_q)) begin
        err_d   = 1'b1;
        state_d = DONE;
      end else if (eq) begin
        result_d = mid;
        found_d  = 1'b1;
        state_d  = DONE;
      end else if (gr) begin
        lo_d = mid + WIDTH'(1);
      end else begin
        hi_d = mid - WIDTH'(1);
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '1;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      found_q  <= found_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end
`ifdef SAR_PROBE_CNT_EN
  localparam int PW = $clog2(WIDTH+2);
  logic [PW-1:0] probes_q;
  assign probes = probes_q;
  always_ff @(posedge clk) begin
    if (rst || (state_q == IDLE && start)) probes_q <= '0;
    else if (state_q == PROBE) probes_q <= probes_q + PW'(1);
  end
`endif
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: directed checks of sar_search against a behavioural comparator (WIDTH=4).
module tb_sar_search;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] guess, result, a = '0;
  logic       gr, ls, eq, busy, done, found, err;
  int         mode = 0;
`ifdef SAR_PROBE_CNT_EN
  logic [2:0] probes;
`endif
  int         n_cmp = 0, n_bad = 0, ng;
  logic [3:0] gs[8];
  logic       done_at_end, done_after, busy_after;

  sar_search #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .guess(guess),
    .gr(gr), .ls(ls), .eq(eq), .busy(busy), .done(done),
    .found(found), .err(err), .result(result)
`ifdef SAR_PROBE_CNT_EN
    , .probes(probes)
`endif
  );

  always #5 clk = ~clk;

  // mode 0: honest comparator, 1: no flag asserted, 2: always "less"
  assign {gr, ls, eq} = mode == 1 ? 3'b000 : mode == 2 ? 3'b010 : {a > guess, a < guess, a == guess};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic search(input logic [3:0] a_v, input int m, input int start_at);
    a = a_v;
    mode = m;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    ng = 0;
    while (busy === 1'b1 && ng < 8) begin
      gs[ng] = guess;
      if (ng == start_at) start = 1'b1;
      ng++;
      @(negedge clk);
      start = 1'b0;
    end
    done_at_end = done;
    @(negedge clk);
    done_after = done;
    busy_after = busy;
  endtask

  task automatic verify(input string t, input int en, input logic [19:0] eg,
                        input logic ef, input logic ee, input logic [3:0] er);
    chk({t, "_nprobe"}, ng, en);
    for (int i = 0; i < en && i < 5; i++) chk($sformatf("%s_g%0d", t, i), gs[i], eg[4*i +: 4]);
    chk({t, "_done"}, done_at_end, 1);
    chk({t, "_done_1cyc"}, done_after, 0);
    chk({t, "_idle_after"}, busy_after, 0);
    chk({t, "_found"}, found, ef);
    chk({t, "_err"}, err, ee);
    chk({t, "_result"}, result, er);
`ifdef SAR_PROBE_CNT_EN
    chk({t, "_probes"}, probes, en);
`endif
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_guess", guess, 0);
    rst = 1'b0;
    search(4'd7, 0, -1);
    verify("a7", 1, 20'h00007, 1, 0, 4'd7);
    search(4'd5, 0, -1);
    verify("a5", 3, 20'h00537, 1, 0, 4'd5);
    search(4'd0, 0, -1);
    verify("a0", 4, 20'h00137, 1, 0, 4'd0);
    search(4'd15, 0, -1);
    verify("a15", 5, 20'hFEDB7, 1, 0, 4'd15);
    search(4'd9, 1, -1);
    verify("flags000", 1, 20'h00007, 0, 1, 4'd0);
    search(4'd9, 2, -1);
    verify("ls_always", 4, 20'h00137, 0, 1, 4'd0);
    search(4'd15, 0, 2);
    verify("start_busy", 5, 20'hFEDB7, 1, 0, 4'd15);
    @(negedge clk);
    chk("start_busy_no_restart", busy, 0);
    a = 4'd12;
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("rstmid_g0", guess, 7);
    @(negedge clk);
    chk("rstmid_g1", guess, 11);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_guess", guess, 0);
    chk("rstmid_found", found, 0);
    @(negedge clk);
    chk("rstmid_no_done", done, 0);
    chk("rstmid_idle", busy, 0);
    search(4'd12, 0, -1);
    verify("a12", 4, 20'h0CDB7, 1, 0, 4'd12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
